// File: rtl/mavg_pkg.sv
// Shared definitions for the moving-average slicer and the bit-recovery blocks:
// width helpers derived from the window length and the FILL/RUN state encoding.
package mavg_pkg;

    localparam logic ST_FILL = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    typedef enum logic {
        S_FILL = ST_FILL,
        S_RUN  = ST_RUN
    } mavg_state_e;

    // Data width: one bit more than the window index so a full count of N fits.
    function automatic int calc_w(input int n);
        return $clog2(n) + 1;
    endfunction

    // Accumulator width: holds N * (2**W - 1) without overflow.
    function automatic int calc_sw(input int n);
        return calc_w(n) + $clog2(n);
    endfunction

    function automatic bit is_pow2(input int n);
        return (n > 0) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/mavg_slicer_if.sv
// Sample/decision bus between the oversampling counter, the slicer and bit recovery.
// master: the side feeding samples and consuming decisions; slave: the slicer.
interface mavg_slicer_if #(
    parameter int W = 5
) ();
    logic         Clear;
    logic [W-1:0] DataIn;
    logic         DataInValid;
    logic         DataOut;
    logic         DataOutValid;
    logic [W-1:0] Average;

    modport master (
        output Clear, DataIn, DataInValid,
        input  DataOut, DataOutValid, Average
    );

    modport slave (
        input  Clear, DataIn, DataInValid,
        output DataOut, DataOutValid, Average
    );
endinterface

// File: rtl/mavg_window_ram.sv
// N x W window buffer, single port, read-before-write: the combinational read
// returns the sample being overwritten in the same cycle.
module mavg_window_ram #(
    parameter int N = 16,
    parameter int W = 5,
    localparam int AW = $clog2(N)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata
);
    logic [W-1:0] mem [N];

    assign rdata = mem[addr];

    // Store the incoming sample at the current window slot.
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end
endmodule

// File: rtl/mavg_slicer.sv
// Moving-average slicer: keeps the last N = SAMPLES*OSF counts, averages them and
// slices each new count against the average into a registered bit with a strobe.
// Optional hysteresis band around the average: define MAVG_SLICER_HYST_EN.
module mavg_slicer
    import mavg_pkg::*;
#(
    parameter int SAMPLES = 2,
    parameter int OSF     = 8,
    parameter int HYST    = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    mavg_slicer_if.slave bus
);
    localparam int N  = SAMPLES * OSF;
    localparam int L  = $clog2(N);
    localparam int W  = calc_w(N);
    localparam int SW = calc_sw(N);

    if (!is_pow2(N)) begin : g_bad_n
        $error("mavg_slicer: SAMPLES*OSF must be a power of two");
    end
    if (HYST < 0 || HYST > (1 << W) - 1) begin : g_bad_hyst
        $error("mavg_slicer: HYST out of range 0..2**W-1");
    end

`ifdef MAVG_SLICER_HYST_EN
    localparam logic [W:0] MAXV   = (W+1)'((1 << W) - 1);
    localparam logic [W:0] HYST_W = (W+1)'(HYST);
`endif

    // Set threshold (hi) and release threshold (lo) in W+1 bits, saturated to 0..2**W-1.
    function automatic logic slice_bit(input logic [W-1:0] s, input logic [W-1:0] a,
                                       input logic prev);
        logic [W:0] hi;
        logic [W:0] lo;
`ifdef MAVG_SLICER_HYST_EN
        hi = {1'b0, a} + HYST_W;
        if (hi > MAXV) hi = MAXV;
        lo = ({1'b0, a} > HYST_W) ? ({1'b0, a} - HYST_W) : '0;
`else
        hi = {1'b0, a};
        lo = {1'b0, a};
`endif
        if ({1'b0, s} >= hi) return 1'b1;
        if ({1'b0, s} < lo)  return 1'b0;
        return prev;
    endfunction

    mavg_state_e    state_q, state_d;
    logic [L-1:0]   wr_ptr;
    logic [L-1:0]   fill_cnt;
    logic [W-1:0]   ram_rd;
    logic [W-1:0]   old;
    logic           take;
    logic           last_fill;
    logic [SW-1:0]  sum_p1;
    logic [W-1:0]   sample_p1;
    logic           vld_p1;
    logic           run_p1;
    logic [W-1:0]   avg_p1;
    logic [W-1:0]   avg_p2;
    logic           dout_p2;
    logic           vld_p2;

    mavg_window_ram #(.N(N), .W(W)) u_ram (
        .clk   (clk),
        .we    (take),
        .addr  (wr_ptr),
        .wdata (bus.DataIn),
        .rdata (ram_rd)
    );

    assign avg_p1           = sum_p1[SW-1:L];
    assign bus.Average      = avg_p2;
    assign bus.DataOut      = dout_p2;
    assign bus.DataOutValid = vld_p2;

    // Next state and accept logic; Clear drops a simultaneous sample.
    always_comb begin
        take      = bus.DataInValid && !bus.Clear;
        last_fill = (state_q == S_FILL) && (fill_cnt == L'(N - 1));
        old       = (state_q == S_FILL) ? '0 : ram_rd;
        state_d   = state_q;
        if (bus.Clear)              state_d = S_FILL;
        else if (take && last_fill) state_d = S_RUN;
    end

    // FILL/RUN state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_FILL;
        else        state_q <= state_d;
    end

    // ---- stage 1: window update and running sum ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_p1   <= '0;
            wr_ptr   <= '0;
            fill_cnt <= '0;
            vld_p1   <= 1'b0;
            run_p1   <= 1'b0;
        end else if (bus.Clear) begin
            sum_p1   <= '0;
            wr_ptr   <= '0;
            fill_cnt <= '0;
            vld_p1   <= 1'b0;
            run_p1   <= 1'b0;
        end else begin
            vld_p1 <= take;
            run_p1 <= take && ((state_q == S_RUN) || last_fill);
            if (take) begin
                sum_p1 <= sum_p1 - SW'(old) + SW'(bus.DataIn);
                wr_ptr <= wr_ptr + 1'b1;
                if (state_q == S_FILL && !last_fill) fill_cnt <= fill_cnt + 1'b1;
            end
        end
    end

    // Sample held for the stage-2 comparison.
    always_ff @(posedge clk) begin
        if (take) sample_p1 <= bus.DataIn;
    end

    // ---- stage 2: average register and slicing decision ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            avg_p2  <= '0;
            dout_p2 <= 1'b0;
            vld_p2  <= 1'b0;
        end else if (bus.Clear) begin
            avg_p2  <= '0;
            dout_p2 <= 1'b0;
            vld_p2  <= 1'b0;
        end else begin
            vld_p2 <= run_p1;
            if (vld_p1) avg_p2  <= avg_p1;
            if (run_p1) dout_p2 <= slice_bit(sample_p1, avg_p1, dout_p2);
        end
    end
endmodule

// File: tb/tb_mavg_slicer.sv
// Bench for mavg_slicer: directed steps plus random traffic against a queue-based
// model of the moving average. Build with MAVG_SLICER_HYST_EN for the hysteresis variant.
module tb_mavg_slicer;
    localparam int N    = 16;
    localparam int W    = 5;
    localparam int HYST = 1;
    localparam int MAXV = (1 << W) - 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mavg_slicer_if #(.W(W)) bus ();

    mavg_slicer #(.SAMPLES(2), .OSF(8), .HYST(HYST)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    int hist[$];
    int total;
    int exp_avg, exp_dout, exp_dv;
    bit pend_valid, pend_run;
    int pend_sample, pend_avg;
    int acc;

    function automatic int decide(input int s, input int a, input int prev);
        int hi, lo;
`ifdef MAVG_SLICER_HYST_EN
        hi = a + HYST;
        lo = a - HYST;
        if (hi > MAXV) hi = MAXV;
        if (lo < 0) lo = 0;
`else
        hi = a;
        lo = a;
`endif
        if (s >= hi) return 1;
        if (s < lo) return 0;
        return prev;
    endfunction

    task automatic model_clear();
        hist.delete();
        total       = 0;
        exp_avg     = 0;
        exp_dout    = 0;
        exp_dv      = 0;
        pend_valid  = 0;
        pend_run    = 0;
        pend_sample = 0;
        pend_avg    = 0;
    endtask

    // Outputs expected after one clock edge with the given inputs.
    task automatic model_edge(input bit clr, input bit v, input int d);
        int s;
        if (clr) begin
            model_clear();
            return;
        end
        exp_dv = 0;
        if (pend_valid) begin
            exp_avg = pend_avg;
            if (pend_run) begin
                exp_dout = decide(pend_sample, pend_avg, exp_dout);
                exp_dv   = 1;
            end
        end
        pend_valid = v;
        pend_run   = 0;
        if (v) begin
            hist.push_back(d);
            if (hist.size() > N) void'(hist.pop_front());
            total++;
            s = 0;
            foreach (hist[i]) s += hist[i];
            pend_avg    = s / N;
            pend_run    = (total >= N);
            pend_sample = d;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_dv"},   32'(bus.DataOutValid), 32'(exp_dv));
        check({tag, "_dout"}, 32'(bus.DataOut),      32'(exp_dout));
        check({tag, "_avg"},  32'(bus.Average),      32'(exp_avg));
    endtask

    task automatic step(input string tag, input bit clr, input bit v, input int d);
        bus.Clear       = clr;
        bus.DataInValid = v;
        bus.DataIn      = W'(d);
        @(posedge clk);
        model_edge(clr, v, d);
        #1;
        check_all(tag);
    endtask

    initial begin
        int d;
        bit v;
        rst_n           = 1'b0;
        bus.Clear       = 1'b0;
        bus.DataInValid = 1'b0;
        bus.DataIn      = '0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check("rst_dv",   32'(bus.DataOutValid), 0);
        check("rst_dout", 32'(bus.DataOut),      0);
        check("rst_avg",  32'(bus.Average),      0);
        #2 rst_n = 1'b1;

        // 1: traffic, then asynchronous reset in the middle of the stream
        for (int i = 0; i < 20; i++) step("pre", 0, 1, $urandom_range(0, MAXV));
        #3 rst_n = 1'b0;
        #1;
        check("rstmid_dv",   32'(bus.DataOutValid), 0);
        check("rstmid_dout", 32'(bus.DataOut),      0);
        check("rstmid_avg",  32'(bus.Average),      0);
        model_clear();
        @(posedge clk);
        #3 rst_n = 1'b1;

        // 2: fill with 16 samples of 5
        for (int i = 0; i < N; i++) step("fill", 0, 1, 5);
        check("fill_dv_early", 32'(bus.DataOutValid), 0);
        step("fill_idle", 0, 0, 0);
        check("fill_dv",  32'(bus.DataOutValid), 1);
        check("fill_avg", 32'(bus.Average),      5);
`ifdef MAVG_SLICER_HYST_EN
        check("fill_dout", 32'(bus.DataOut), 0);
`else
        check("fill_dout", 32'(bus.DataOut), 1);
`endif

        // 3: step from a window of 4s to an 8
        for (int i = 0; i < N; i++) step("base4", 0, 1, 4);
        step("step8", 0, 1, 8);
        step("step8_idle", 0, 0, 0);
        check("step_avg",  32'(bus.Average), 4);
        check("step_dout", 32'(bus.DataOut), 1);

        // 4: band around average 4
        step("hy4", 0, 1, 4);
        step("hy4_idle", 0, 0, 0);
        check("hy4_dout", 32'(bus.DataOut), 1);
        step("hy2", 0, 1, 2);
        step("hy2_idle", 0, 0, 0);
        check("hy2_dout", 32'(bus.DataOut), 0);
        step("hy5", 0, 1, 5);
        step("hy5_idle", 0, 0, 0);

        // 5: Clear together with a valid sample
        step("pre_clr", 0, 1, 7);
        step("clr", 1, 1, 31);
        check("clr_dv",  32'(bus.DataOutValid), 0);
        check("clr_avg", 32'(bus.Average),      0);
        acc = 0;
        for (int i = 0; i < N; i++) begin
            d = $urandom_range(0, MAXV);
            acc += d;
            step("refill", 0, 1, d);
            check("refill_dv", 32'(bus.DataOutValid), 0);
        end
        step("refill_idle", 0, 0, 0);
        check("refill_dv_on", 32'(bus.DataOutValid), 1);
        check("refill_avg",   32'(bus.Average),      32'(acc / N));

        // saturation corners: full-scale and zero windows
        for (int i = 0; i < N + 2; i++) step("all31", 0, 1, MAXV);
        for (int i = 0; i < N + 2; i++) step("all0", 0, 1, 0);

        // 6: random samples with gaps, extremes weighted
        for (int i = 0; i < 200; i++) begin
            v = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0:       d = 0;
                1:       d = MAXV;
                default: d = $urandom_range(0, MAXV);
            endcase
            step("rand", 0, v, d);
        end
        step("tail1", 0, 0, 0);
        step("tail2", 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
